// File: rtl/dsp_mac_sequencer.sv
// Dot-product scheduler for one DSP48A1 slice: streams A/B pairs, sequences OPMODE, captures P.
// Optional subtract-per-beat support is enabled with `define DSP_SEQ_SUB_EN.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int TAG_DLY = 1,
  parameter int P_LAT   = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
`ifdef DSP_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_p
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic sub;
  } tag_t;

  state_t                 state;
  logic [LEN_W-1:0]       cnt;
  logic                   first_q;
  tag_t [TAG_DLY-1:0]     tag_q;
  tag_t                   tag_o;
  logic                   beat;
  logic                   beat_sub;

  assign beat = in_valid & in_ready;

`ifdef DSP_SEQ_SUB_EN
  assign beat_sub = in_sub;
`else
  assign beat_sub = 1'b0;
`endif

  // Operands go straight into the slice's A1/B1 registers; zero outside STREAM.
  assign dsp_a = in_ready ? in_a : '0;
  assign dsp_b = in_ready ? in_b : '0;

  // The tag leaving the delay line lines up with its product in the M register.
  assign tag_o = tag_q[TAG_DLY-1];
  always_comb begin
    dsp_opmode      = 8'h00;
    dsp_opmode[1:0] = tag_o.vld ? 2'b01 : 2'b00;
    dsp_opmode[3:2] = (tag_o.vld & tag_o.first) ? 2'b00 : 2'b10;
    dsp_opmode[7]   = tag_o.vld & tag_o.sub;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      first_q   <= 1'b0;
      tag_q     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_p     <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: beat, first: beat & first_q, sub: beat & beat_sub};
      for (int i = 1; i < TAG_DLY; i++) tag_q[i] <= tag_q[i-1];

      case (state)
        IDLE: begin
          if (start && len != '0) begin
            cnt      <= len;
            first_q  <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (beat) begin
            first_q <= 1'b0;
            if (cnt == LEN_W'(1)) begin
              // Counter is reused to time the slice pipeline after the last beat.
              cnt      <= LEN_W'(P_LAT - 1);
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            res_p     <= dsp_p;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
